// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Shifts one bit per clock into the binary field and corrects every BCD digit with subtract-3.
module bcd_to_bin_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned SregW = BcdW + BIN_W;
  localparam int unsigned CntW  = $clog2(BIN_W + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q, state_d;
  logic [SregW-1:0]   sreg_q, sreg_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;

  logic               bad_digit;
  logic               last_shift;
  logic [SregW-1:0]   dabbled;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Shift right, then pull every digit that reached 8+ back down by 3 (inverse of add-3).
  always_comb begin
    dabbled = sreg_q >> 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (dabbled[BIN_W + 4*i +: 4] >= 4'd8) begin
        dabbled[BIN_W + 4*i +: 4] = dabbled[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
  end

  assign last_shift = (count_q == CntW'(BIN_W - 1));

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    count_d = count_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (bad_digit) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            bin_d  = '0;
          end else begin
            sreg_d  = {bcd_in, {BIN_W{1'b0}}};
            count_d = '0;
            err_d   = 1'b0;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        sreg_d  = dabbled;
        count_d = count_q + CntW'(1);
        if (last_shift) begin
          bin_d   = dabbled[BIN_W-1:0];
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  // Valid BCD always drains completely once BIN_W shifts are done.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StShift && last_shift) begin
      assert (dabbled[SregW-1:BIN_W] == '0);
    end
  end

  assign busy    = (state_q == StShift);
  assign done    = done_q;
  assign bin_out = bin_q;
  assign err     = err_q;

endmodule
